// File: rtl/tmcu_apb_fabric_if.sv
// Bus bundle between the CPU-side AHB-lite port and the APB peripheral slots.
// The fabric uses the slave modport: it is an AHB slave and drives the APB side.
// The master modport is the view of whatever surrounds the fabric.
interface tmcu_apb_fabric_if #(
  parameter int NUM_SLV   = 4,
  parameter int SLOT_BITS = 12
);
  // AHB-lite side
  logic                   hsel;
  logic [31:0]            haddr;
  logic [1:0]             htrans;
  logic                   hwrite;
  logic [2:0]             hsize;
  logic [31:0]            hwdata;
  logic [31:0]            hrdata;
  logic                   hready;
  logic                   hresp;
  // APB side
  logic [NUM_SLV-1:0]     psel;
  logic                   penable;
  logic                   pwrite;
  logic [SLOT_BITS-1:0]   paddr;
  logic [31:0]            pwdata;
  logic [3:0]             pstrb;
  logic [32*NUM_SLV-1:0]  prdata;
  logic [NUM_SLV-1:0]     pready;
  logic [NUM_SLV-1:0]     pslverr;
  // Watchdog abort pulse
  logic                   timeout;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata,
    output hrdata, hready, hresp,
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr,
    output timeout
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata,
    input  hrdata, hready, hresp,
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr,
    input  timeout
  );
endinterface

// File: rtl/tmcu_apb_fabric.sv
// AHB-lite slave fanned out to NUM_SLV APB slots with one-hot psel, byte
// strobes, wait-state handling, slave-error forwarding and an access watchdog.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for an address phase, OKAY zero-wait response
// CAPT   | AHB data phase: capture hwdata, APB controls already driven
// SETUP  | APB setup phase: psel high, penable low
// ACCESS | APB access phase: wait for pready, count wait cycles
// ERR1   | first ERROR cycle: hready low, hresp high, no psel
// ERR2   | second ERROR cycle: hready high, hresp high, starts ignored
module tmcu_apb_fabric #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          SLOT_BITS   = 12,
  parameter int          TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              rst,
  tmcu_apb_fabric_if.slave bus
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [32:0]   WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0]   WIN_HI    = WIN_LO + (33'(NUM_SLV) << SLOT_BITS);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 hready_q, hready_d;
  logic                 hresp_q, hresp_d;
  logic [31:0]          hrdata_q, hrdata_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [SLOT_BITS-1:0] paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [3:0]           pstrb_q, pstrb_d;
  logic                 timeout_q, timeout_d;

  logic                 start;
  logic                 in_win;
  logic                 dec_err;
  logic [31:0]          offset;
  logic [SW-1:0]        dec_slot;
  logic [3:0]           dec_strb;
  logic                 sel_ready;
  logic                 sel_err;
  logic [31:0]          sel_rdata;
  logic                 unused_htrans;

  // NONSEQ and SEQ both start a transfer, so only htrans[1] matters
  assign unused_htrans = bus.htrans[0];

  // Address-phase decode: window check, slot index, size/alignment and strobes
  always_comb begin
    start    = bus.hsel & bus.htrans[1] & hready_q;
    offset   = bus.haddr - BASE_ADDR;
    dec_slot = SW'(offset >> SLOT_BITS);
    in_win   = ({1'b0, bus.haddr} >= WIN_LO) && ({1'b0, bus.haddr} < WIN_HI);
    dec_err  = !in_win
             || (bus.hsize > 3'd2)
             || ((bus.hsize == 3'd1) && bus.haddr[0])
             || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
    case (bus.hsize)
      3'd0:    dec_strb = 4'b0001 << bus.haddr[1:0];
      3'd1:    dec_strb = 4'b0011 << bus.haddr[1:0];
      default: dec_strb = 4'b1111;
    endcase
  end

  // Only the selected slot's response is ever looked at
  always_comb begin
    sel_ready = bus.pready[slot_q];
    sel_err   = bus.pslverr[slot_q];
    sel_rdata = bus.prdata[32*slot_q +: 32];
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    wait_cnt_d = wait_cnt_q;
    hrdata_d   = hrdata_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    timeout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dec_err) begin
            state_d = S_ERR1;
          end else begin
            state_d  = S_CAPT;
            slot_d   = dec_slot;
            pwrite_d = bus.hwrite;
            paddr_d  = bus.haddr[SLOT_BITS-1:0];
            pstrb_d  = bus.hwrite ? dec_strb : 4'b0000;
          end
        end
      end
      S_CAPT: begin
        pwdata_d   = bus.hwdata;
        wait_cnt_d = '0;
        state_d    = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          if (sel_err) begin
            state_d = S_ERR1;
          end else begin
            if (!pwrite_q) hrdata_d = sel_rdata;
            state_d = S_IDLE;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          // This is the TIMEOUT_CYC-th ACCESS cycle without pready: abort
          timeout_d = 1'b1;
          state_d   = S_ERR1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // AHB/APB handshake outputs are registered, so derive them from state_d
    hready_d  = (state_d == S_IDLE) || (state_d == S_ERR2);
    hresp_d   = (state_d == S_ERR1) || (state_d == S_ERR2);
    penable_d = (state_d == S_ACCESS);
    if ((state_d == S_SETUP) || (state_d == S_ACCESS)) begin
      psel_d = NUM_SLV'(1) << slot_d;
    end else begin
      psel_d = '0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      wait_cnt_q <= '0;
      hready_q   <= 1'b1;
      hresp_q    <= 1'b0;
      hrdata_q   <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      wait_cnt_q <= wait_cnt_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      hrdata_q   <= hrdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.hrdata  = hrdata_q;
  assign bus.hready  = hready_q;
  assign bus.hresp   = hresp_q;
  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.pstrb   = pstrb_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_tmcu_apb_fabric.sv
// Directed bench for tmcu_apb_fabric: a vector table of single transfers run
// back-to-back, plus hand sequences for idle/BUSY, ERR2 start, and reset.
module tb_tmcu_apb_fabric;

  localparam int NUM_SLV   = 4;
  localparam int SLOT_BITS = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] exp_hrdata = 32'h0;

  always #5 clk = ~clk;

  tmcu_apb_fabric_if #(.NUM_SLV(NUM_SLV), .SLOT_BITS(SLOT_BITS)) bus_if ();

  tmcu_apb_fabric #(
    .NUM_SLV    (NUM_SLV),
    .BASE_ADDR  (32'h4000_0000),
    .SLOT_BITS  (SLOT_BITS),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    int          exp_done;
    logic        exp_resp;
    logic [3:0]  exp_psel;
    logic [11:0] exp_paddr;
    logic [3:0]  exp_pstrb;
    int          exp_acc;
    int          exp_tmo;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus_if.hsel   = 1'b0;
    bus_if.htrans = 2'b00;
    bus_if.haddr  = 32'h0;
    bus_if.hwrite = 1'b0;
    bus_if.hsize  = 3'd0;
  endtask

  task automatic set_prdata(input logic [3:0] sel, input logic [31:0] val);
    for (int i = 0; i < NUM_SLV; i++)
      bus_if.prdata[32*i +: 32] = sel[i] ? val : (32'hBAD0_0000 | 32'(i));
  endtask

  // Called with the current cycle able to take an address phase (hready=1).
  task automatic run_xfer(input int idx, input vec_t v);
    int   n, done, acc, tmo, psel_cyc;
    logic resp_prev;
    bus_if.hsel    = 1'b1;
    bus_if.htrans  = 2'b10;
    bus_if.haddr   = v.haddr;
    bus_if.hwrite  = v.hwrite;
    bus_if.hsize   = v.hsize;
    bus_if.pready  = '0;
    bus_if.pslverr = '0;
    set_prdata(v.exp_psel, v.prdata);
    @(posedge clk); #1;
    drive_idle();
    bus_if.hwdata = v.hwdata;
    n = 1; done = 0; acc = 0; tmo = 0; psel_cyc = 0; resp_prev = 1'b0;
    while (done == 0 && n <= 20) begin
      @(negedge clk);
      if (bus_if.timeout) tmo++;
      if (bus_if.psel != '0) psel_cyc++;
      if (bus_if.penable && bus_if.psel != '0) begin
        acc++;
        if (acc == 1) begin
          chk($sformatf("v%0d psel", idx), 32'(bus_if.psel), 32'(v.exp_psel));
          chk($sformatf("v%0d paddr", idx), 32'(bus_if.paddr), 32'(v.exp_paddr));
          chk($sformatf("v%0d pstrb", idx), 32'(bus_if.pstrb), 32'(v.exp_pstrb));
          chk($sformatf("v%0d pwrite", idx), 32'(bus_if.pwrite), 32'(v.hwrite));
          if (v.hwrite) chk($sformatf("v%0d pwdata", idx), bus_if.pwdata, v.hwdata);
        end
        bus_if.pready  = (acc > v.waits) ? v.exp_psel : 4'b0000;
        bus_if.pslverr = (acc > v.waits && v.slverr) ? v.exp_psel : 4'b0000;
      end else begin
        bus_if.pready  = '0;
        bus_if.pslverr = '0;
      end
      if (bus_if.hready) begin
        done = n;
      end else begin
        resp_prev = bus_if.hresp;
        @(posedge clk);
        n++;
      end
    end
    if (!v.hwrite && !v.exp_resp) exp_hrdata = v.prdata;
    chk($sformatf("v%0d done_cycle", idx), 32'(done), 32'(v.exp_done));
    chk($sformatf("v%0d hresp_done", idx), 32'(bus_if.hresp), 32'(v.exp_resp));
    chk($sformatf("v%0d hrdata", idx), bus_if.hrdata, exp_hrdata);
    chk($sformatf("v%0d access_cycles", idx), 32'(acc), 32'(v.exp_acc));
    chk($sformatf("v%0d psel_cycles", idx), 32'(psel_cyc),
        32'((v.exp_acc > 0) ? v.exp_acc + 1 : 0));
    chk($sformatf("v%0d timeout_pulses", idx), 32'(tmo), 32'(v.exp_tmo));
    if (v.exp_resp) begin
      chk($sformatf("v%0d err1_hresp", idx), 32'(resp_prev), 32'd1);
      // ERR2 ignores starts, so leave one idle cycle before the next transfer
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d post_err_hready", idx), 32'(bus_if.hready), 32'd1);
      chk($sformatf("v%0d post_err_hresp", idx), 32'(bus_if.hresp), 32'd0);
    end
  endtask

  initial begin
    int k;
    //          haddr          wr  sz  hwdata         prdata         wt sl  done rsp psel     paddr   pstrb    acc tmo
    vecs[0]  = '{32'h4000_1004, 1, 2, 32'hDEADBEEF, 32'h0,         0, 0,  4,  0, 4'b0010, 12'h004, 4'b1111, 1, 0};
    vecs[1]  = '{32'h4000_2003, 0, 0, 32'h0,        32'h11223344,  3, 0,  7,  0, 4'b0100, 12'h003, 4'b0000, 4, 0};
    vecs[2]  = '{32'h4000_4000, 0, 2, 32'h0,        32'h0,         0, 0,  2,  1, 4'b0000, 12'h000, 4'b0000, 0, 0};
    vecs[3]  = '{32'h4000_0002, 1, 2, 32'h12345678, 32'h0,         0, 0,  2,  1, 4'b0000, 12'h000, 4'b0000, 0, 0};
    vecs[4]  = '{32'h4000_0010, 1, 2, 32'hA5A5A5A5, 32'h0,         0, 1,  5,  1, 4'b0001, 12'h010, 4'b1111, 1, 0};
    vecs[5]  = '{32'h4000_3006, 1, 1, 32'h0000ABCD, 32'h0,         1, 0,  5,  0, 4'b1000, 12'h006, 4'b1100, 2, 0};
    vecs[6]  = '{32'h4000_0001, 1, 0, 32'h00005500, 32'h0,         0, 0,  4,  0, 4'b0001, 12'h001, 4'b0010, 1, 0};
    vecs[7]  = '{32'h4000_0000, 0, 3, 32'h0,        32'h0,         0, 0,  2,  1, 4'b0000, 12'h000, 4'b0000, 0, 0};
    vecs[8]  = '{32'h4000_1001, 0, 1, 32'h0,        32'h0,         0, 0,  2,  1, 4'b0000, 12'h000, 4'b0000, 0, 0};
    vecs[9]  = '{32'h4000_3FFC, 0, 2, 32'h0,        32'h77777777, 99, 0,  8,  1, 4'b1000, 12'hFFC, 4'b0000, 4, 1};
    vecs[10] = '{32'h4000_1FF0, 0, 2, 32'h0,        32'h5A5AA5A5,  2, 0,  6,  0, 4'b0010, 12'hFF0, 4'b0000, 3, 0};
    vecs[11] = '{32'h3FFF_FFFC, 0, 2, 32'h0,        32'h0,         0, 0,  2,  1, 4'b0000, 12'h000, 4'b0000, 0, 0};
    vecs[12] = '{32'h4000_2100, 0, 2, 32'h0,        32'h99999999,  2, 1,  7,  1, 4'b0100, 12'h100, 4'b0000, 3, 0};
    vecs[13] = '{32'h4000_2402, 1, 1, 32'hBEEF0000, 32'h0,         0, 0,  4,  0, 4'b0100, 12'h402, 4'b1100, 1, 0};

    drive_idle();
    bus_if.hwdata  = 32'h0;
    bus_if.prdata  = '0;
    bus_if.pready  = '0;
    bus_if.pslverr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    chk("rst hready",  32'(bus_if.hready),  32'd1);
    chk("rst hresp",   32'(bus_if.hresp),   32'd0);
    chk("rst hrdata",  bus_if.hrdata,       32'd0);
    chk("rst psel",    32'(bus_if.psel),    32'd0);
    chk("rst penable", 32'(bus_if.penable), 32'd0);
    chk("rst pwrite",  32'(bus_if.pwrite),  32'd0);
    chk("rst paddr",   32'(bus_if.paddr),   32'd0);
    chk("rst pwdata",  bus_if.pwdata,       32'd0);
    chk("rst pstrb",   32'(bus_if.pstrb),   32'd0);
    chk("rst timeout", 32'(bus_if.timeout), 32'd0);

    // Table transfers issued back-to-back (no bubble after OKAY completions)
    for (int i = 0; i < 14; i++) run_xfer(i, vecs[i]);

    // BUSY with hsel, then NONSEQ without hsel: both stay idle, OKAY
    bus_if.hsel = 1'b1; bus_if.htrans = 2'b01; bus_if.haddr = 32'h4000_1000;
    @(posedge clk); @(negedge clk);
    chk("busy hready", 32'(bus_if.hready), 32'd1);
    chk("busy psel",   32'(bus_if.psel),   32'd0);
    bus_if.hsel = 1'b0; bus_if.htrans = 2'b10;
    @(posedge clk); @(negedge clk);
    chk("nosel hready", 32'(bus_if.hready), 32'd1);
    chk("nosel hresp",  32'(bus_if.hresp),  32'd0);
    drive_idle();
    @(posedge clk); @(negedge clk);
    chk("nosel psel", 32'(bus_if.psel), 32'd0);

    // Start presented during ERR2 must be dropped
    bus_if.hsel = 1'b1; bus_if.htrans = 2'b10; bus_if.haddr = 32'h4000_4000; bus_if.hsize = 3'd2;
    @(posedge clk); #1 drive_idle();
    @(negedge clk);
    chk("err2seq err1 hready", 32'(bus_if.hready), 32'd0);
    chk("err2seq err1 hresp",  32'(bus_if.hresp),  32'd1);
    @(posedge clk); #1;
    bus_if.hsel = 1'b1; bus_if.htrans = 2'b10; bus_if.haddr = 32'h4000_1000; bus_if.hsize = 3'd2;
    @(negedge clk);
    chk("err2seq err2 hready", 32'(bus_if.hready), 32'd1);
    chk("err2seq err2 hresp",  32'(bus_if.hresp),  32'd1);
    @(posedge clk); #1 drive_idle();
    @(negedge clk);
    chk("err2seq idle hready", 32'(bus_if.hready), 32'd1);
    chk("err2seq idle hresp",  32'(bus_if.hresp),  32'd0);
    @(posedge clk); @(negedge clk);
    chk("err2seq ignored hready", 32'(bus_if.hready), 32'd1);
    chk("err2seq ignored psel",   32'(bus_if.psel),   32'd0);

    // Reset asserted during ACCESS, then a clean read to slot1
    bus_if.hsel = 1'b1; bus_if.htrans = 2'b10; bus_if.haddr = 32'h4000_1008;
    bus_if.hwrite = 1'b0; bus_if.hsize = 3'd2;
    bus_if.pready = '0; bus_if.pslverr = '0;
    @(posedge clk); #1 drive_idle();
    k = 0;
    @(negedge clk);
    while (!bus_if.penable && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rstseq reached access", 32'(bus_if.penable), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_hrdata = 32'h0;
    @(negedge clk);
    chk("rstseq psel",    32'(bus_if.psel),    32'd0);
    chk("rstseq penable", 32'(bus_if.penable), 32'd0);
    chk("rstseq hready",  32'(bus_if.hready),  32'd1);
    chk("rstseq hresp",   32'(bus_if.hresp),   32'd0);
    chk("rstseq hrdata",  bus_if.hrdata,       32'd0);
    run_xfer(100, '{32'h4000_1008, 0, 2, 32'h0, 32'hCAFEF00D, 0, 0, 4, 0,
                    4'b0010, 12'h008, 4'b0000, 1, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
